// File: rtl/seq_divider.sv
// Sequential signed 32/32 divider: one restoring step per clock, sign
// fix-up at the end, registered results and a one-cycle done pulse.
//
// Ports:
//   clock        rising-edge clock
//   clear        asynchronous active-high reset
//   start        request a divide (accepted only when idle)
//   A, B         signed dividend / divisor, sampled on the accepting edge
//   busy         high while a division is in progress
//   done         one-cycle pulse marking valid results
//   quotient     signed quotient, truncated toward zero
//   remainder    signed remainder, carries the dividend's sign
//   div_by_zero  set with done when B was zero
module seq_divider (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] FIXUP = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state;
  logic [5:0]  count;
  logic [31:0] rem;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic        neg_q;
  logic        neg_r;
  logic        dz;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] shl;
  logic [32:0] diff;
  logic [31:0] q_fin;
  logic [31:0] r_src;
  logic [31:0] r_fin;

  // Magnitudes are taken as unsigned 32-bit values, so the most
  // negative operand maps to 2^31 without overflow.
  always_comb begin
    abs_a = A[31] ? (~A + 32'd1) : A;
    abs_b = B[31] ? (~B + 32'd1) : B;
  end

  // Restoring step. The partial remainder is always below |B| <= 2^31,
  // so the shifted value fits in 32 bits; the 33rd bit of the trial
  // difference is the borrow.
  always_comb begin
    shl  = {rem, dvd[31]};
    diff = shl - {1'b0, dvs};
  end

  // On divide-by-zero the dividend register still holds |A|, so the
  // sign fix-up reproduces A exactly as the remainder.
  always_comb begin
    if (dz) begin
      q_fin = 32'hFFFF_FFFF;
    end else if (neg_q) begin
      q_fin = ~dvd + 32'd1;
    end else begin
      q_fin = dvd;
    end
    r_src = dz ? dvd : rem;
    r_fin = neg_r ? (~r_src + 32'd1) : r_src;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state       <= IDLE;
      count       <= 6'd0;
      rem         <= 32'd0;
      dvd         <= 32'd0;
      dvs         <= 32'd0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      quotient    <= 32'd0;
      remainder   <= 32'd0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd   <= abs_a;
            dvs   <= abs_b;
            neg_r <= A[31];
            neg_q <= A[31] ^ B[31];
            rem   <= 32'd0;
            count <= 6'd0;
            dz    <= (B == 32'd0);
            state <= (B == 32'd0) ? FIXUP : CALC;
          end
        end
        CALC: begin
          rem   <= diff[32] ? shl[31:0] : diff[31:0];
          dvd   <= {dvd[30:0], ~diff[32]};
          count <= count + 6'd1;
          if (count == 6'd31) begin
            state <= FIXUP;
          end
        end
        FIXUP: begin
          quotient    <= q_fin;
          remainder   <= r_fin;
          div_by_zero <= dz;
          state       <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    busy = (state == CALC) || (state == FIXUP);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized scoreboard bench for seq_divider with an arithmetic
// reference model and latency / hold / reset checks.
module tb_seq_divider;

  logic        clock;
  logic        clear;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  seq_divider dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        hold;
  int          cyc;
  int          n_checks;
  int          n_fail;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain signed arithmetic with truncation toward zero.
  // The 64-bit quotient of MIN/-1 is 2^31, which truncates to the
  // required wrapped value 32'h80000000 with remainder 0.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint la;
    longint lb;
    longint lq;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    e.due = 0;
    if (b == 32'd0) begin
      e.q  = 32'hFFFF_FFFF;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      lq   = la / lb;
      e.q  = lq[31:0];
      e.r  = 32'(la - lq * lb);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: pops on every done pulse, otherwise checks that the
  // result registers hold the last result.
  always @(negedge clock) begin
    exp_t e;
    if (!clear) begin
      if (done) begin
        chk("busy_in_done", {63'd0, busy}, 64'd0);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected none at cyc %0d",
                   cyc);
        end else begin
          e = sb.pop_front();
          chk("quotient", {32'd0, quotient}, {32'd0, e.q});
          chk("remainder", {32'd0, remainder}, {32'd0, e.r});
          chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dz});
          chk("latency", 64'(cyc), 64'(e.due));
          hold = e;
        end
      end else begin
        chk("hold", {quotient, remainder}, {hold.q, hold.r});
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clock);
    while ((busy || done) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=%0b expected idle", busy);
    end
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    wait_idle();
    start = 1'b1;
    A = a;
    B = b;
    @(posedge clock);
    #1;
    e = model(a, b);
    e.due = cyc + ((b == 32'd0) ? 1 : 33);
    sb.push_back(e);
    start = 1'b0;
    A = $urandom;
    B = $urandom;
  endtask

  task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start = 1'b1;
    A = a;
    B = b;
    @(negedge clock);
    start = 1'b0;
  endtask

  function automatic logic [31:0] rnd_op(input bit divisor);
    int sel;
    sel = int'($urandom_range(0, 9));
    if (sel == 0) return divisor ? 32'd0 : 32'h8000_0000;
    if (sel == 1) return divisor ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
    if (sel <= 4) return 32'($signed(int'($urandom_range(0, 400)) - 200));
    return $urandom;
  endfunction

  initial begin
    int n;
    n_checks = 0;
    n_fail   = 0;
    hold     = '{q: 32'd0, r: 32'd0, dz: 1'b0, due: 0};
    clear    = 1'b1;
    start    = 1'b1;
    A        = 32'd5;
    B        = 32'd1;
    repeat (3) @(negedge clock);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_q", {32'd0, quotient}, 64'd0);
    chk("rst_r", {32'd0, remainder}, 64'd0);
    chk("rst_dz", {63'd0, div_by_zero}, 64'd0);
    start = 1'b0;
    clear = 1'b0;

    do_div(32'd100, 32'd7);
    do_div(-32'sd100, 32'd7);
    do_div(32'd100, -32'sd7);
    do_div(32'h8000_0000, 32'hFFFF_FFFF);
    do_div(32'd55, 32'd0);
    do_div(32'd9, 32'd3);

    // start while busy and start during DONE must both be ignored
    do_div(32'd1000, 32'd3);
    repeat (5) @(posedge clock);
    pulse_start(32'd8, 32'd2);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clock);
      n++;
    end
    start = 1'b1;
    A = 32'd1;
    B = 32'd1;
    @(negedge clock);
    start = 1'b0;
    chk("start_in_done", {63'd0, busy}, 64'd0);

    // clear in the middle of CALC aborts with no done pulse
    do_div(32'd1000, 32'd3);
    repeat (10) @(posedge clock);
    #1;
    clear = 1'b1;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_q", {32'd0, quotient}, 64'd0);
    chk("abort_r", {32'd0, remainder}, 64'd0);
    chk("abort_dz", {63'd0, div_by_zero}, 64'd0);
    void'(sb.pop_back());
    hold = '{q: 32'd0, r: 32'd0, dz: 1'b0, due: 0};
    @(negedge clock);
    clear = 1'b0;
    do_div(32'd7, 32'd2);

    for (int i = 0; i < 40; i++) begin
      do_div(rnd_op(1'b0), rnd_op(1'b1));
    end

    n = 0;
    while ((sb.size() != 0 || busy || done) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
